serial_xs3_codec: RTL
=====================

SERIAL_XS3_CODEC -- requirements
Module: serial_xs3_codec

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, the number of 4-bit digits per frame (legal 1..16).
REQ-002 The block SHALL have port Clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Rst, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have port En, input, 1 bit, the bit-valid qualifier: X is consumed only in cycles with En=1.
REQ-005 The block SHALL have port Mode, input, 1 bit, the conversion direction: 0 = Excess-3 to BCD, 1 = BCD to Excess-3.
REQ-006 The block SHALL have port X, input, 1 bit, the serial code input, LSB first.
REQ-007 The block SHALL have port Z, output, 1 bit, the serial converted output, Mealy, valid in the same cycle as X.
REQ-008 The block SHALL have port DigitDone, output, 1 bit, high in the cycle where the 4th bit of a digit is consumed.
REQ-009 The block SHALL have port FrameDone, output, 1 bit, high in the cycle where the last bit of the last digit of a frame is consumed.
REQ-010 The block SHALL have port Err, output, 1 bit, invalid-code flag, qualified by DigitDone.

Function
REQ-011 The block SHALL keep a 2-bit bit index (0..3), a digit index (0..DIGITS-1), a carry bit, a latched mode bit and a 3-bit history of the current digit's bits 0..2.
REQ-012 The block SHALL latch Mode only when En=1 at bit index 0 of digit index 0, and SHALL ignore Mode changes at all other points of a frame.
REQ-013 The latched mode bit SHALL govern the whole frame; the cycle that latches Mode SHALL already use the new value.
REQ-014 The block SHALL use constant K = 1101 (minus 3 mod 16) in mode 0 and K = 0011 (plus 3) in mode 1.
REQ-015 In an En=1 cycle at bit index i, Z SHALL equal X xor K[i] xor C, where C is 0 at i=0 and the stored carry otherwise.
REQ-016 In that cycle the stored carry SHALL update to majority(X, K[i], C); the carry out of bit 3 SHALL be discarded.
REQ-017 When En=0, Z, DigitDone, FrameDone and Err SHALL be 0, and all state SHALL hold.
REQ-018 The bit index SHALL increment on each En=1 cycle and wrap 3 to 0; at that wrap the digit index SHALL increment.
REQ-019 The digit index SHALL wrap from DIGITS-1 to 0; FrameDone SHALL equal DigitDone AND (digit index = DIGITS-1).
REQ-020 With DIGITS=1, FrameDone SHALL equal DigitDone.
REQ-021 Err SHALL be high with DigitDone when the assembled digit {X, history} is invalid for the latched mode.
REQ-022 An Excess-3 digit SHALL be invalid outside 0011..1100; a BCD digit SHALL be invalid above 1001.
REQ-023 Z SHALL still follow REQ-015 for an invalid digit; the following digit SHALL convert normally.
REQ-024 Latency SHALL be zero: Z for bit i SHALL be combinational from X, state and latched mode in the same cycle.

Reset
REQ-025 On a rising Clk edge with Rst=1, the block SHALL clear the bit index, digit index, carry, history and latched mode to 0.
REQ-026 While Rst=1, Z, DigitDone, FrameDone and Err SHALL be forced to 0, regardless of En and X.
REQ-027 Rst asserted mid-digit or mid-frame SHALL abandon the partial digit; the first En=1 cycle after release SHALL be bit 0 of digit 0 and SHALL latch Mode.
REQ-028 Rst SHALL take priority over En in the same cycle.

Configuration
REQ-029 With macro SERIAL_XS3_CODEC_ERR_EN defined, the block SHALL include the validity check and history register of REQ-021 and REQ-022.
REQ-030 Without SERIAL_XS3_CODEC_ERR_EN, Err SHALL be tied to 0, the history register SHALL be omitted, and all other behaviour SHALL be unchanged.

Verification
REQ-031 Excess-3 to BCD digit: DIGITS=1, Mode=0, En=1, X=1,1,1,0 (0111) -> Z=0,0,1,0 (0100); DigitDone=FrameDone=1 on the 4th bit; Err=0.
REQ-032 BCD to Excess-3 digit: Mode=1, X=1,0,0,1 (1001) -> Z=0,0,1,1 (1100); in the same frame, BCD 1010 -> Err=1 with DigitDone (ERR_EN defined).
REQ-033 Frame wrap with mode hold: DIGITS=2, Mode toggled in cycle 2 of a frame, Excess-3 0011 then 1100 -> BCD 0000 then 1001; mode stays 0; FrameDone only on cycle 8.
REQ-034 Stall: En=0 inserted between bits 1 and 2 of Excess-3 0101 for 3 cycles -> outputs 0 during the stall; Z sequence 0,1,0,0 (BCD 0010) is unchanged.
REQ-035 Mid-digit reset: Rst=1 for 1 cycle after 2 bits -> outputs 0 during reset; the next 4 bits 0,0,1,1 (Excess-3 1100) -> Z=1,0,0,1 (BCD 1001) with DigitDone at the 4th bit.
REQ-036 Invalid Excess-3: Excess-3 0001 with ERR_EN defined -> Err=1 on DigitDone; with ERR_EN not defined -> Err=0, and Z is identical in both builds.

Source files
------------

// File: rtl/serial_xs3_codec.sv
// Bit-serial Excess-3 <-> BCD converter: adds the constant K (1101 or 0011) LSB first, one bit per enabled cycle.
// Optional validity check enabled by defining SERIAL_XS3_CODEC_ERR_EN.
module serial_xs3_codec #(
    parameter int DIGITS = 4
) (
    input  logic Clk,
    input  logic Rst,
    input  logic En,
    input  logic Mode,
    input  logic X,
    output logic Z,
    output logic DigitDone,
    output logic FrameDone,
    output logic Err
);

    localparam int DIGIT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(DIGITS - 1);

    logic [1:0]         bit_idx_reg;
    logic [DIGIT_W-1:0] digit_idx_reg;
    logic               carry_reg;
    logic               mode_reg;

    logic               frame_start;
    logic               mode_eff;
    logic [3:0]         k_const;
    logic               k_bit;
    logic               carry_in;
    logic               active;
    logic               digit_done;

    // The very first bit of a frame already converts with the incoming Mode.
    assign frame_start = (bit_idx_reg == 2'd0) && (digit_idx_reg == '0);
    assign mode_eff    = frame_start ? Mode : mode_reg;
    assign k_const     = mode_eff ? 4'b0011 : 4'b1101;
    assign k_bit       = k_const[bit_idx_reg];
    assign carry_in    = (bit_idx_reg == 2'd0) ? 1'b0 : carry_reg;
    assign active      = En && !Rst;
    assign digit_done  = active && (bit_idx_reg == 2'd3);

    assign Z         = active && (X ^ k_bit ^ carry_in);
    assign DigitDone = digit_done;
    assign FrameDone = digit_done && (digit_idx_reg == LAST_DIGIT);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            bit_idx_reg   <= 2'd0;
            digit_idx_reg <= '0;
            carry_reg     <= 1'b0;
            mode_reg      <= 1'b0;
        end else if (En) begin
            bit_idx_reg <= bit_idx_reg + 2'd1;
            if (frame_start) begin
                mode_reg <= Mode;
            end
            if (bit_idx_reg == 2'd3) begin
                carry_reg <= 1'b0;
                if (digit_idx_reg == LAST_DIGIT) begin
                    digit_idx_reg <= '0;
                end else begin
                    digit_idx_reg <= digit_idx_reg + DIGIT_W'(1);
                end
            end else begin
                carry_reg <= (X & k_bit) | (X & carry_in) | (k_bit & carry_in);
            end
        end
    end

`ifdef SERIAL_XS3_CODEC_ERR_EN
    logic [2:0] hist_reg;
    logic [3:0] digit_val;
    logic       invalid;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_hist
            always_ff @(posedge Clk) begin
                if (Rst) begin
                    hist_reg[gi] <= 1'b0;
                end else if (En && (bit_idx_reg == 2'(gi))) begin
                    hist_reg[gi] <= X;
                end
            end
        end
    endgenerate

    // Bit 3 arrives live on X, so the full digit is only visible in the DigitDone cycle.
    always_comb begin
        digit_val = {X, hist_reg};
        if (mode_eff) begin
            invalid = digit_val > 4'd9;
        end else begin
            invalid = (digit_val < 4'd3) || (digit_val > 4'd12);
        end
    end

    assign Err = digit_done && invalid;
`else
    assign Err = 1'b0;
`endif

endmodule
